// File: rtl/csr_unit.sv
// csr_unit: multi-cycle Zicsr execution unit in front of the machine-mode CSR file.
// It reads the target CSR and applies the read-modify-write rule. For write
// forms it writes the result back. It returns the old CSR value for rd, or
// flags the access as illegal.
module csr_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        KILL,
  input  logic [2:0]  FUNCT3,
  input  logic [11:0] CSR_ADDR,
  input  logic [31:0] RS1_DATA,
  input  logic [4:0]  RS1_FIELD,
  input  logic [4:0]  RD_ADDR,
  input  logic [31:0] CSR_RDATA_REG,
  output logic [11:0] CSR_RADDR,
  output logic [11:0] CSR_WADDR,
  output logic [31:0] CSR_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ILLEGAL,
  output logic        RD_WE,
  output logic [4:0]  RD_ADDR_OUT,
  output logic [31:0] RD_WDATA
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_MODIFY = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Machine-mode CSRs implemented by the downstream CSR file.
  function automatic logic addr_legal(input logic [11:0] a);
    case (a)
      12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'hB00, 12'hB80, 12'hB02, 12'hB82: addr_legal = 1'b1;
      default:                            addr_legal = 1'b0;
    endcase
  endfunction

  // Counters are read-only in the CSR file, so any write to them is illegal.
  function automatic logic addr_counter(input logic [11:0] a);
    case (a)
      12'hB00, 12'hB80, 12'hB02, 12'hB82: addr_counter = 1'b1;
      default:                            addr_counter = 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] src_q, src_d;
  logic        do_write_q, do_write_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] old_q, old_d;
  logic [11:0] raddr_q, raddr_d;
  logic [11:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic        rd_we_q, rd_we_d;
  logic [4:0]  rd_addr_out_q, rd_addr_out_d;
  logic [31:0] rd_wdata_q, rd_wdata_d;

  logic [31:0] src_s;
  logic        do_write_s;
  logic        illegal_s;
  logic [31:0] new_s;
  logic        wr_block_s;

  // Decode the incoming request: operand select, write intent and legality.
  always_comb begin
    src_s      = FUNCT3[2] ? {27'd0, RS1_FIELD} : RS1_DATA;
    do_write_s = (FUNCT3[1:0] == 2'b01) ? 1'b1 : (RS1_FIELD != 5'd0);
    illegal_s  = (FUNCT3[1:0] == 2'b00) || !addr_legal(CSR_ADDR) ||
                 (do_write_s && addr_counter(CSR_ADDR));
  end

  // Read-modify-write result from the CSR file's registered read data.
  always_comb begin
    case (op_q)
      2'b01:   new_s = src_q;
      2'b10:   new_s = CSR_RDATA_REG | src_q;
      2'b11:   new_s = CSR_RDATA_REG & ~src_q;
      default: new_s = src_q;
    endcase
  end

  // Next-state and next-output logic for the whole operation sequence.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    src_d         = src_q;
    do_write_d    = do_write_q;
    rd_addr_d     = rd_addr_q;
    old_d         = old_q;
    raddr_d       = raddr_q;
    waddr_d       = 12'h000;
    wdata_d       = 32'h0000_0000;
    done_d        = 1'b0;
    illegal_d     = illegal_q;
    rd_we_d       = 1'b0;
    rd_addr_out_d = rd_addr_out_q;
    rd_wdata_d    = rd_wdata_q;
    case (state_q)
      S_IDLE: begin
        raddr_d = 12'h000;
        if (START && !KILL) begin
          op_d       = FUNCT3[1:0];
          addr_d     = CSR_ADDR;
          src_d      = src_s;
          do_write_d = do_write_s;
          rd_addr_d  = RD_ADDR;
          if (illegal_s) begin
            state_d       = S_DONE;
            done_d        = 1'b1;
            illegal_d     = 1'b1;
            rd_wdata_d    = 32'h0000_0000;
            rd_addr_out_d = RD_ADDR;
          end else begin
            state_d = S_READ;
            raddr_d = CSR_ADDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (KILL) begin
          state_d = S_IDLE;
          raddr_d = 12'h000;
        end else begin
          state_d = S_MODIFY;
        end
      end
      S_MODIFY: begin
        if (KILL) begin
          state_d = S_IDLE;
          raddr_d = 12'h000;
        end else begin
          state_d = S_WRITE;
          old_d   = CSR_RDATA_REG;
          if (do_write_q) begin
            waddr_d = addr_q;
            wdata_d = new_s;
          end else begin
            waddr_d = 12'h000;
            wdata_d = 32'h0000_0000;
          end
        end
      end
      S_WRITE: begin
        raddr_d = 12'h000;
        if (KILL) begin
          state_d = S_IDLE;
        end else begin
          state_d       = S_DONE;
          done_d        = 1'b1;
          illegal_d     = 1'b0;
          rd_wdata_d    = old_q;
          rd_addr_out_d = rd_addr_q;
          rd_we_d       = (rd_addr_q != 5'd0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        raddr_d = 12'h000;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      op_q          <= 2'b00;
      addr_q        <= 12'h000;
      src_q         <= 32'h0000_0000;
      do_write_q    <= 1'b0;
      rd_addr_q     <= 5'd0;
      old_q         <= 32'h0000_0000;
      raddr_q       <= 12'h000;
      waddr_q       <= 12'h000;
      wdata_q       <= 32'h0000_0000;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      rd_we_q       <= 1'b0;
      rd_addr_out_q <= 5'd0;
      rd_wdata_q    <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      src_q         <= src_d;
      do_write_q    <= do_write_d;
      rd_addr_q     <= rd_addr_d;
      old_q         <= old_d;
      raddr_q       <= raddr_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      rd_we_q       <= rd_we_d;
      rd_addr_out_q <= rd_addr_out_d;
      rd_wdata_q    <= rd_wdata_d;
    end
  end

  // A flush or reset during the write cycle must cancel that write immediately.
  assign wr_block_s  = KILL | RST;
  assign CSR_WADDR   = wr_block_s ? 12'h000 : waddr_q;
  assign CSR_WDATA   = wr_block_s ? 32'h0000_0000 : wdata_q;
  assign CSR_RADDR   = raddr_q;
  assign BUSY        = (state_q != S_IDLE);
  assign DONE        = done_q;
  assign ILLEGAL     = illegal_q;
  assign RD_WE       = rd_we_q;
  assign RD_ADDR_OUT = rd_addr_out_q;
  assign RD_WDATA    = rd_wdata_q;

endmodule

// File: doc/csr_unit.md
# csr_unit

Multi-cycle CSR instruction execution unit sitting directly upstream of the machine-mode CSR file. It accepts one decoded Zicsr instruction at a time and drives the CSR file's read address, then its write address and data. It captures the CSR file's registered read data and computes the read-modify-write result. It returns the old CSR value for register writeback and flags illegal CSR accesses.

## Interface
Parameters: none.

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  synchronous, active-high reset
- START  in  1  request; sampled only in IDLE
- KILL  in  1  pipeline flush; aborts any in-flight op
- FUNCT3  in  3  Zicsr funct3
- CSR_ADDR  in  12  target CSR
- RS1_DATA  in  32  rs1 register value
- RS1_FIELD  in  5  rs1 index / uimm field
- RD_ADDR  in  5  destination register
- CSR_RDATA_REG  in  32  registered read data from CSR file
- CSR_RADDR  out  12  CSR file read address
- CSR_WADDR  out  12  CSR file write address; 0 = no write
- CSR_WDATA  out  32  CSR file write data
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- ILLEGAL  out  1  valid with DONE; access was illegal
- RD_WE  out  1  DONE && !ILLEGAL && RD_ADDR_OUT != 0
- RD_ADDR_OUT  out  5  latched RD_ADDR
- RD_WDATA  out  32  old CSR value; 0 when ILLEGAL

## Operation
- States: IDLE, READ, MODIFY, WRITE, DONE.
- IDLE: on START && !KILL, latch FUNCT3, CSR_ADDR, RS1_DATA, RS1_FIELD and RD_ADDR.
  - If the access is legal, go to READ.
  - If it is illegal, go to DONE with ILLEGAL=1.
- Legal addresses: 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0xB00 mcycle, 0xB80 mcycleh, 0xB02 minstret, 0xB82 minstreth.
- ILLEGAL is set when any of the following holds:
  - FUNCT3 is 000 or 100.
  - The address is not in the legal list.
  - do_write=1 and the target is a counter address (0xB00, 0xB80, 0xB02, 0xB82). The CSR file treats counters as read-only.
- Source operand: src = RS1_DATA when FUNCT3[2]=0; src = {27'b0, RS1_FIELD} when FUNCT3[2]=1.
- do_write:
  - CSRRW/CSRRWI (FUNCT3[1:0]=01): always 1.
  - CSRRS/CSRRC and immediate forms (FUNCT3[1:0]=10/11): 1 only when RS1_FIELD != 0.
- READ: CSR_RADDR = latched address, registered and stable from READ through WRITE.
- MODIFY: capture CSR_RDATA_REG into old; compute new value.
  - RW: new = src.
  - RS: new = old | src.
  - RC: new = old & ~src.
- WRITE: for exactly this cycle, CSR_WADDR = latched address and CSR_WDATA = new, gated by do_write && !KILL. Otherwise CSR_WADDR = 0.
- DONE: DONE=1; RD_WDATA = old (0 if ILLEGAL); next state IDLE.
- RD_WDATA, RD_ADDR_OUT and ILLEGAL hold their values until the next DONE.
- CSRRW with rd=0 still performs the read; CSRs have no read side effects, which keeps latency fixed.
- KILL in any non-IDLE state:
  - Next state is IDLE.
  - No DONE is issued.
  - No CSR write occurs in that cycle or later.
- START while BUSY is ignored. START && KILL in IDLE is not accepted.

## Timing
- Reset values: BUSY, DONE, ILLEGAL, RD_WE = 0; RD_WDATA, CSR_WDATA = 0; CSR_RADDR, CSR_WADDR, RD_ADDR_OUT = 0; state = IDLE.
- Legal op with START at cycle 0:
  - READ in c1.
  - MODIFY in c2; the CSR file captured the read at end of c1.
  - WRITE in c3; the CSR file updates at end of c3.
  - DONE in c4.
  - IDLE in c5; next START is accepted in c5.
- Illegal op: DONE/ILLEGAL in c1, IDLE in c2, no CSR write.
- The read snapshot is taken at the end of c1. Counter reads return the value present at that edge.
- A CSR write in WRITE has priority over a simultaneous trap update of mepc/mcause inside the CSR file.
- RST in any state returns to IDLE next cycle and suppresses any pending write.

## Test plan
- mscratch=0x0000_00F0; CSRRS 0x340 with RS1_DATA=0x0F, RS1_FIELD=5, RD_ADDR=3 → DONE at c4, RD_WDATA=0xF0, RD_WE=1; mscratch becomes 0xFF.
- mtvec=0x8000_0100; CSRRCI 0x305 with uimm=0 → exactly one CSR_RADDR=0x305 read; CSR_WADDR stays 0 throughout; RD_WDATA=0x8000_0100.
- CSRRW 0xB00 with RS1_DATA=5 → ILLEGAL=1 and DONE in c1, RD_WE=0, no write. CSRRS 0xB00 with RS1_FIELD=0 → legal, returns the cycle count.
- FUNCT3=100, or address 0x7C0 → ILLEGAL at c1, RD_WDATA=0.
- CSRRW 0x341 with KILL asserted in c3 → CSR_WADDR=0 in c3, no DONE, BUSY=0 in c4, mepc unchanged.
- Back-to-back ops: START held high → second op accepted only in c5. Also assert RST in MODIFY → all outputs return to reset values next cycle.
